uart_tx_fifo: RTL
=================

// Module: uart_tx_fifo
// PURPOSE
//  Show-ahead synchronous transmit FIFO between the CPU-side SBUF write path and the UART interface.
//  CPU writes bytes in with wr_en/wr_data.
//  The UART interface pops with r_en and samples fifo_data, which always shows the head byte.
//  Reports full/empty/almost-full, occupancy and sticky overflow/underflow error flags.
// PARAMETERS
//  DEPTH        16  entries; power of two, >= 4
//  AW            4  pointer width = log2(DEPTH)
//  AFULL_THRESH 12  almost_full asserted when count >= AFULL_THRESH (1..DEPTH)
// PORTS
//  clk_uart    in   1     single clock; all state changes on its rising edge
//  rst         in   1     synchronous, active-high reset
//  wr_en       in   1     push request, one byte per cycle
//  wr_data     in   8     byte to push
//  r_en        in   1     pop request from UART interface, one byte per cycle
//  fifo_data   out  8     head byte (show-ahead); 8'h00 when empty
//  fifo_empty  out  1     no entries
//  fifo_full   out  1     count == DEPTH
//  almost_full out  1     count >= AFULL_THRESH
//  count       out  AW+1  occupancy, 0..DEPTH
//  overflow    out  1     sticky: push attempted while full and not accepted
//  underflow   out  1     sticky: pop attempted while empty
//  err_clr     in   1     clears overflow/underflow
// BEHAVIOUR
//  Reset (rst=1 at an edge): wr_ptr=rd_ptr=0, count=0.
//   fifo_empty=1, fifo_full=0, almost_full=0, overflow=0, underflow=0, fifo_data=8'h00.
//   Storage array is not cleared.
//   Reset wins over every other input in the same cycle, including mid-burst pushes and pops.
//  Storage: DEPTH x 8 register array; pointers are AW bits and wrap DEPTH-1 -> 0 naturally.
//   count holds the full/empty distinction.
//  Push accepted = wr_en & (~fifo_full | pop_accepted).
//   On accept: mem[wr_ptr] <= wr_data; wr_ptr <= wr_ptr+1.
//  Pop accepted = r_en & ~fifo_empty. On accept: rd_ptr <= rd_ptr+1.
//  fifo_data = mem[rd_ptr] combinationally, and is valid whenever fifo_empty=0.
//   The consumer samples fifo_data in the cycle it asserts r_en.
//   The next entry appears the cycle after the pop edge.
//  Latency: a byte pushed at edge N is visible on fifo_data and clears fifo_empty after edge N.
//   There is no bypass: a push into an empty FIFO is not poppable in the same cycle.
//  count: +1 on push only, -1 on pop only, unchanged on both or neither.
//   Flags are derived from the registered count.
//  Simultaneous push and pop:
//   Full: both accepted; count stays DEPTH; no overflow.
//   Empty: push accepted, pop rejected, underflow set; count becomes 1.
//   Otherwise: both accepted; count unchanged.
//  Errors:
//   wr_en while full without an accepted pop -> byte dropped, overflow <= 1.
//   r_en while empty -> ignored, underflow <= 1.
//   Both flags stay set until err_clr=1 or reset.
//   err_clr has priority over a new error in the same cycle (flag reads 0 after that edge).
//  Pointers never move on rejected requests; count never exceeds DEPTH or goes below 0.
// TESTING
//  T1 reset: assert rst for 2 cycles mid-traffic.
//   -> next cycle fifo_empty=1, count=0, fifo_data=8'h00, both error flags 0.
//  T2 fill/drain: push 8'hD9..8'hE8 (16 bytes), then pop 16.
//   -> almost_full rises at count=12, fifo_full at 16.
//   -> pops return D9..E8 in order; fifo_empty=1 after the last pop.
//  T3 wrap: push 10, pop 10, push 10, pop 10 with incrementing data.
//   -> order preserved across the pointer wrap; count returns to 0.
//  T4 full + simultaneous: at count=16 assert wr_en=1 (8'hAA) and r_en=1 together.
//   -> count stays 16, overflow=0, and 8'hAA is read back as the last byte.
//  T5 errors: wr_en while full (no pop) -> overflow=1, count=16, data unchanged.
//   -> r_en on empty sets underflow=1.
//   -> err_clr with a new overflow in the same cycle -> overflow reads 0.
//  T6 loopback: drive the UART interface from fifo_data/fifo_empty/r_en, prefilled with 8'hD9,8'hDA,8'hDB.
//   -> receiver r_data shows D9, DA, DB in order; fifo_empty=1 afterwards.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - show-ahead transmit FIFO between the SBUF write path and the UART interface
module uart_tx_fifo #(
   parameter int DEPTH        = 16,
   parameter int AW           = 4,
   parameter int AFULL_THRESH = 12
) (
   input  logic          clk_uart,
   input  logic          rst,
   input  logic          wr_en,
   input  logic [7:0]    wr_data,
   input  logic          r_en,
   input  logic          err_clr,
   output logic [7:0]    fifo_data,
   output logic          fifo_empty,
   output logic          fifo_full,
   output logic          almost_full,
   output logic [AW:0]   count,
   output logic          overflow,
   output logic          underflow
);

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          push_acc;
   logic          pop_acc;

   assign fifo_empty  = (count == '0);
   assign fifo_full   = (count == (AW+1)'(DEPTH));
   assign almost_full = (count >= (AW+1)'(AFULL_THRESH));

   // A pop frees the head slot, so a push into a full FIFO is accepted alongside it.
   assign pop_acc  = r_en & ~fifo_empty;
   assign push_acc = wr_en & (~fifo_full | pop_acc);

   assign fifo_data = fifo_empty ? 8'h00 : mem[rd_ptr];

   always_ff @(posedge clk_uart) begin
      if (!rst && push_acc)
         mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk_uart) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (push_acc)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop_acc)
            rd_ptr <= rd_ptr + 1'b1;
         case ({push_acc, pop_acc})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         // Clearing wins over an error raised in the same cycle.
         if (err_clr) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
         end else begin
            if (wr_en && !push_acc)
               overflow <= 1'b1;
            if (r_en && fifo_empty)
               underflow <= 1'b1;
         end
      end
   end

endmodule
